issue_scoreboard: RTL and testbench

Dual-issue register scoreboard sitting between decode and the issue stage, in front of the 2-write/4-read register file. It tracks outstanding writes per architectural register with small counters, grants issue to slot 1 and slot 2 in program order only when their source operands are available from the register file, either from the array or through its same-cycle write forwarding, and updates the counters from both write-back ports. It also owns pipeline-flush recovery of the pending-write state.

---
 rtl/issue_scoreboard_if.sv | 46 ++++
 rtl/issue_scoreboard.sv | 140 ++++++++++++++
 tb/tb_issue_scoreboard.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/issue_scoreboard_if.sv
// Decode-to-issue and write-back bundle for issue_scoreboard.
// master: decode/write-back side. slave: the scoreboard.
interface issue_scoreboard_if #(
    parameter int unsigned REG_ADDR_W = 5
) ();
    // Decode slots (slot 1 is older)
    logic                  valid_1;
    logic                  valid_2;
    logic                  re1_1;
    logic                  re2_1;
    logic                  re1_2;
    logic                  re2_2;
    logic [REG_ADDR_W-1:0] raddr1_1;
    logic [REG_ADDR_W-1:0] raddr2_1;
    logic [REG_ADDR_W-1:0] raddr1_2;
    logic [REG_ADDR_W-1:0] raddr2_2;
    logic                  we_1;
    logic                  we_2;
    logic [REG_ADDR_W-1:0] waddr_1;
    logic [REG_ADDR_W-1:0] waddr_2;
    // Write-back ports
    logic                  wb_we_1;
    logic                  wb_we_2;
    logic [REG_ADDR_W-1:0] wb_waddr_1;
    logic [REG_ADDR_W-1:0] wb_waddr_2;
    // Issue decision
    logic                  issue_1;
    logic                  issue_2;
    logic                  stall;

    modport master (
        output valid_1, valid_2, re1_1, re2_1, re1_2, re2_2,
        output raddr1_1, raddr2_1, raddr1_2, raddr2_2,
        output we_1, we_2, waddr_1, waddr_2,
        output wb_we_1, wb_we_2, wb_waddr_1, wb_waddr_2,
        input  issue_1, issue_2, stall
    );

    modport slave (
        input  valid_1, valid_2, re1_1, re2_1, re1_2, re2_2,
        input  raddr1_1, raddr2_1, raddr1_2, raddr2_2,
        input  we_1, we_2, waddr_1, waddr_2,
        input  wb_we_1, wb_we_2, wb_waddr_1, wb_waddr_2,
        output issue_1, issue_2, stall
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Dual-issue register scoreboard with per-register outstanding-write counters.
// Sources are ready when no write is pending after accounting for same-cycle
// write-back (the register file forwards wdata). Register 0 is never tracked.
// Optional macro ISSUE_SB_STAT_EN adds stall_cycles / dual_issue_cycles counters.
module issue_scoreboard #(
    parameter int unsigned REG_NUM    = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    issue_scoreboard_if.slave  sb,
    output logic [REG_NUM-1:0] busy_vec,
    output logic               underflow_err
`ifdef ISSUE_SB_STAT_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        dual_issue_cycles
`endif
);

    localparam int unsigned SumW = CNT_W + 1;
    localparam int unsigned NxtW = CNT_W + 2;
    localparam logic [SumW-1:0] CntMax = SumW'((1 << CNT_W) - 1);

    logic [CNT_W-1:0]   cnt_q   [REG_NUM];
    logic [CNT_W-1:0]   cnt_d   [REG_NUM];
    logic [CNT_W-1:0]   eff     [REG_NUM];
    logic [CNT_W-1:0]   applied [REG_NUM];
    logic [1:0]         dec     [REG_NUM];
    logic [1:0]         inc     [REG_NUM];
    logic [NxtW-1:0]    nxt     [REG_NUM];
    logic [REG_NUM-1:0] under_vec;
    logic [REG_NUM-1:0] busy_d;
    logic [REG_NUM-1:0] busy_q;
    logic               underflow_q;

    logic rdy1_1, rdy2_1, rdy1_2, rdy2_2;
    logic dst1_ok, dst2_ok, same_dst, raw;
    logic issue_1, issue_2;

    // Per-register write-back decrement and effective (post-forwarding) count
    always_comb begin
        for (int r = 0; r < REG_NUM; r++) begin
            dec[r]       = 2'd0;
            eff[r]       = '0;
            applied[r]   = '0;
            under_vec[r] = 1'b0;
            if (r != 0) begin
                if (sb.wb_we_1 && sb.wb_waddr_1 == REG_ADDR_W'(r)) dec[r] = dec[r] + 2'd1;
                if (sb.wb_we_2 && sb.wb_waddr_2 == REG_ADDR_W'(r)) dec[r] = dec[r] + 2'd1;
                if ({1'b0, cnt_q[r]} >= SumW'(dec[r])) begin
                    eff[r]     = cnt_q[r] - CNT_W'(dec[r]);
                    applied[r] = CNT_W'(dec[r]);
                end else begin
                    // Decrements beyond zero are dropped and flagged
                    eff[r]       = '0;
                    applied[r]   = cnt_q[r];
                    under_vec[r] = 1'b1;
                end
            end
        end
    end

    assign rdy1_1 = !sb.re1_1 || (sb.raddr1_1 == '0) || (eff[sb.raddr1_1] == '0);
    assign rdy2_1 = !sb.re2_1 || (sb.raddr2_1 == '0) || (eff[sb.raddr2_1] == '0);
    assign rdy1_2 = !sb.re1_2 || (sb.raddr1_2 == '0) || (eff[sb.raddr1_2] == '0);
    assign rdy2_2 = !sb.re2_2 || (sb.raddr2_2 == '0) || (eff[sb.raddr2_2] == '0);

    // Slot 2's destination limit includes slot 1's increment on a WAW pair
    assign same_dst = sb.we_1 && (sb.waddr_1 != '0) && (sb.waddr_1 == sb.waddr_2);
    assign dst1_ok  = !sb.we_1 || (sb.waddr_1 == '0) || ({1'b0, eff[sb.waddr_1]} < CntMax);
    assign dst2_ok  = !sb.we_2 || (sb.waddr_2 == '0) ||
                      (({1'b0, eff[sb.waddr_2]} + SumW'(same_dst)) < CntMax);

    assign raw = sb.we_1 && (sb.waddr_1 != '0) &&
                 ((sb.re1_2 && (sb.raddr1_2 == sb.waddr_1)) ||
                  (sb.re2_2 && (sb.raddr2_2 == sb.waddr_1)));

    assign issue_1 = sb.valid_1 && !flush && rst && rdy1_1 && rdy2_1 && dst1_ok;
    assign issue_2 = issue_1 && sb.valid_2 && rdy1_2 && rdy2_2 && !raw && dst2_ok;

    assign sb.issue_1 = issue_1;
    assign sb.issue_2 = issue_2;
    assign sb.stall   = rst && ((sb.valid_1 && !issue_1) || (sb.valid_2 && !issue_2));

    // Next counter values from issued writes and applied write-back decrements
    always_comb begin
        for (int r = 0; r < REG_NUM; r++) begin
            inc[r] = 2'd0;
            if (r != 0) begin
                if (issue_1 && sb.we_1 && sb.waddr_1 == REG_ADDR_W'(r)) inc[r] = inc[r] + 2'd1;
                if (issue_2 && sb.we_2 && sb.waddr_2 == REG_ADDR_W'(r)) inc[r] = inc[r] + 2'd1;
            end
            nxt[r]    = NxtW'(cnt_q[r]) + NxtW'(inc[r]) - NxtW'(applied[r]);
            cnt_d[r]  = (r == 0) ? '0 : nxt[r][CNT_W-1:0];
            busy_d[r] = (cnt_d[r] != '0);
        end
    end

    // Counter state: reset beats flush, flush beats issue/write-back
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q       <= '{default: '0};
            busy_q      <= '0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            cnt_q       <= '{default: '0};
            busy_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            underflow_q <= underflow_q | (|under_vec);
        end
    end

    assign busy_vec      = busy_q;
    assign underflow_err = underflow_q;

`ifdef ISSUE_SB_STAT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] dual_cnt_q;

    // Performance counters; cleared only by reset, wrap naturally
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            dual_cnt_q  <= '0;
        end else begin
            if (sb.stall)          stall_cnt_q <= stall_cnt_q + 32'd1;
            if (issue_1 && issue_2) dual_cnt_q  <= dual_cnt_q + 32'd1;
        end
    end

    assign stall_cycles      = stall_cnt_q;
    assign dual_issue_cycles = dual_cnt_q;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed self-checking bench for issue_scoreboard.
// Inputs change 1 time unit after posedge; outputs are sampled 1 unit later.
module tb_issue_scoreboard;

    localparam int unsigned REG_NUM    = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CNT_W      = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic [REG_NUM-1:0] busy_vec;
    logic               underflow_err;
`ifdef ISSUE_SB_STAT_EN
    logic [31:0]        stall_cycles;
    logic [31:0]        dual_issue_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    issue_scoreboard_if #(.REG_ADDR_W(REG_ADDR_W)) sb_if ();

    issue_scoreboard #(
        .REG_NUM    (REG_NUM),
        .REG_ADDR_W (REG_ADDR_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .sb                (sb_if),
        .busy_vec          (busy_vec),
        .underflow_err     (underflow_err)
`ifdef ISSUE_SB_STAT_EN
        ,
        .stall_cycles      (stall_cycles),
        .dual_issue_cycles (dual_issue_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {issue_1, issue_2, stall}
    task automatic check_issue(input string tag, input logic [2:0] exp);
        #1;
        check(tag, {61'd0, sb_if.issue_1, sb_if.issue_2, sb_if.stall}, {61'd0, exp});
    endtask

    task automatic idle();
        flush = 1'b0;
        sb_if.valid_1 = 0; sb_if.valid_2 = 0;
        sb_if.re1_1 = 0; sb_if.re2_1 = 0; sb_if.re1_2 = 0; sb_if.re2_2 = 0;
        sb_if.raddr1_1 = 0; sb_if.raddr2_1 = 0; sb_if.raddr1_2 = 0; sb_if.raddr2_2 = 0;
        sb_if.we_1 = 0; sb_if.we_2 = 0; sb_if.waddr_1 = 0; sb_if.waddr_2 = 0;
        sb_if.wb_we_1 = 0; sb_if.wb_we_2 = 0; sb_if.wb_waddr_1 = 0; sb_if.wb_waddr_2 = 0;
    endtask

    task automatic slot1(input logic we, input logic [4:0] wa, input logic r1,
                         input logic [4:0] a1, input logic r2, input logic [4:0] a2);
        sb_if.valid_1 = 1; sb_if.we_1 = we; sb_if.waddr_1 = wa;
        sb_if.re1_1 = r1; sb_if.raddr1_1 = a1; sb_if.re2_1 = r2; sb_if.raddr2_1 = a2;
    endtask

    task automatic slot2(input logic we, input logic [4:0] wa, input logic r1,
                         input logic [4:0] a1, input logic r2, input logic [4:0] a2);
        sb_if.valid_2 = 1; sb_if.we_2 = we; sb_if.waddr_2 = wa;
        sb_if.re1_2 = r1; sb_if.raddr1_2 = a1; sb_if.re2_2 = r2; sb_if.raddr2_2 = a2;
    endtask

    task automatic wb1(input logic [4:0] a);
        sb_if.wb_we_1 = 1; sb_if.wb_waddr_1 = a;
    endtask

    task automatic wb2(input logic [4:0] a);
        sb_if.wb_we_2 = 1; sb_if.wb_waddr_2 = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset hold: no issue, no stall even with valid slots
        slot1(1, 5'd1, 1, 5'd2, 1, 5'd3);
        slot2(1, 5'd4, 1, 5'd5, 1, 5'd6);
        check_issue("reset_issue", 3'b000);
        tick();
        check("reset_busy", busy_vec, 32'h0);
        check("reset_uflow", underflow_err, 1'b0);

        // Release: independent dual issue
        rst = 1'b1;
        check_issue("dual_nodep", 3'b110);
        tick();
        check("dual_busy", busy_vec, 32'h0000_0012);
        idle(); wb1(5'd1); wb2(5'd4);
        check_issue("wb_only", 3'b000);
        tick();
        check("dual_drain", busy_vec, 32'h0);

        // RAW between slots, then wait for write-back forwarding
        idle(); slot1(1, 5'd5, 0, 5'd0, 0, 5'd0); slot2(0, 5'd0, 1, 5'd5, 0, 5'd0);
        check_issue("raw_slot", 3'b101);
        tick();
        check("raw_busy", busy_vec, 32'h0000_0020);
        idle(); slot1(0, 5'd0, 0, 5'd0, 0, 5'd0); slot2(0, 5'd0, 0, 5'd0, 1, 5'd5);
        check_issue("raw_wait", 3'b101);
        tick();
        wb1(5'd5);
        check_issue("raw_fwd", 3'b110);
        tick();
        check("raw_clear", busy_vec, 32'h0);

        // Counter saturation on r7
        for (int i = 0; i < 3; i++) begin
            idle(); slot1(1, 5'd7, 0, 5'd0, 0, 5'd0);
            check_issue("r7_fill", 3'b100);
            tick();
        end
        check("r7_busy", busy_vec, 32'h0000_0080);
        idle(); slot1(1, 5'd7, 0, 5'd0, 0, 5'd0);
        check_issue("r7_full", 3'b001);
        wb1(5'd7);
        check_issue("r7_wb_issue", 3'b100);
        tick();
        idle(); wb1(5'd7); wb2(5'd7);
        tick();
        check("r7_cnt1", busy_vec, 32'h0000_0080);
        idle(); wb2(5'd7);
        tick();
        check("r7_cnt0", busy_vec, 32'h0);
        check("r7_uflow", underflow_err, 1'b0);

        // WAW dual issue on r9, then double write-back
        idle(); slot1(1, 5'd9, 0, 5'd0, 0, 5'd0); slot2(1, 5'd9, 0, 5'd0, 0, 5'd0);
        check_issue("waw_r9", 3'b110);
        tick();
        check("r9_busy", busy_vec, 32'h0000_0200);
        idle(); wb1(5'd9); wb2(5'd9);
        tick();
        check("r9_clear", busy_vec, 32'h0);
        check("r9_uflow", underflow_err, 1'b0);

        // Destination limit counts slot 1's increment when both write r12
        idle(); slot1(1, 5'd12, 0, 5'd0, 0, 5'd0); slot2(1, 5'd12, 0, 5'd0, 0, 5'd0);
        tick();
        check_issue("r12_limit", 3'b101);
        tick();
        check("r12_busy", busy_vec, 32'h0000_1000);
        idle(); wb1(5'd12); wb2(5'd12);
        tick();
        check("r12_cnt1", busy_vec, 32'h0000_1000);
        idle(); wb1(5'd12);
        tick();
        check("r12_cnt0", busy_vec, 32'h0);

        // Register 0 is never tracked
        idle(); slot1(1, 5'd0, 1, 5'd0, 0, 5'd0); slot2(1, 5'd0, 1, 5'd0, 1, 5'd0);
        check_issue("r0_issue", 3'b110);
        tick();
        check("r0_busy", busy_vec, 32'h0);

        // Flush discards pending writes and same-cycle issue
        idle(); slot1(1, 5'd3, 0, 5'd0, 0, 5'd0); slot2(1, 5'd4, 0, 5'd0, 0, 5'd0);
        tick();
        check("pre_flush_busy", busy_vec, 32'h0000_0018);
        idle(); slot1(1, 5'd6, 0, 5'd0, 0, 5'd0); slot2(0, 5'd0, 0, 5'd0, 0, 5'd0);
        flush = 1'b1;
        check_issue("flush_issue", 3'b001);
        tick();
        check("flush_busy", busy_vec, 32'h0);
        check("flush_uflow", underflow_err, 1'b0);
        idle(); slot2(0, 5'd0, 0, 5'd0, 0, 5'd0);
        check_issue("slot2_alone", 3'b001);
        tick();

        // Stale write-back after flush hits a zero counter
        idle(); wb1(5'd3);
        tick();
        check("stale_uflow", underflow_err, 1'b1);
        idle();
        tick();
        check("uflow_sticky", underflow_err, 1'b1);
        rst = 1'b0;
        tick();
        check("rst_uflow", underflow_err, 1'b0);
        check("rst_busy2", busy_vec, 32'h0);
        rst = 1'b1;

`ifdef ISSUE_SB_STAT_EN
        check("stat_stall_rst", stall_cycles, 32'd0);
        check("stat_dual_rst", dual_issue_cycles, 32'd0);
        idle(); slot1(1, 5'd1, 0, 5'd0, 0, 5'd0); slot2(1, 5'd2, 0, 5'd0, 0, 5'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            idle(); slot1(0, 5'd0, 1, 5'd1, 0, 5'd0);
            tick();
        end
        idle(); slot1(0, 5'd0, 1, 5'd1, 0, 5'd0); slot2(0, 5'd0, 1, 5'd2, 0, 5'd0);
        wb1(5'd1); wb2(5'd2);
        tick();
        check("stat_stall", stall_cycles, 32'd4);
        check("stat_dual", dual_issue_cycles, 32'd2);
        idle(); flush = 1'b1;
        tick();
        check("stat_stall_flush", stall_cycles, 32'd4);
        check("stat_dual_flush", dual_issue_cycles, 32'd2);
        idle(); rst = 1'b0;
        tick();
        check("stat_stall_clr", stall_cycles, 32'd0);
        check("stat_dual_clr", dual_issue_cycles, 32'd0);
        rst = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
